// File: rtl/rom_download_ctrl.sv
// rom_download_ctrl: routes the hps_io ioctl download stream into the
// CRAZYBALLOON ROM regions (CPU program ROM, graphics ROM, colour PROM).
// It also captures the MRA DIP-switch bytes and owns the core reset.
//
// Input protocol: ioctl_wr is a one-cycle byte strobe. There is no
// back-pressure, so every strobe is consumed in the cycle it is seen.
// Each ROM region receives its own write strobe one cycle later.
// That strobe is asserted for exactly one cycle and is qualified by the
// region address and the shared wr_data, which are valid in the same cycle.
//
// o_dbg_state exposes the controller state: 0=BOOT, 1=LOAD, 2=HOLD, 3=RUN.
module rom_download_ctrl #(
    parameter int          RESET_HOLD = 16,
    parameter int          CPU_AW     = 14,
    parameter logic [15:0] GFX_BASE   = 16'h4000,
    parameter int          GFX_AW     = 11,
    parameter logic [15:0] PROM_BASE  = 16'h4800,
    parameter int          PROM_AW    = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ioctl_download,
    input  logic               ioctl_wr,
    input  logic [7:0]         ioctl_index,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    input  logic               ext_reset,
    output logic [7:0]         wr_data,
    output logic               cpu_rom_we,
    output logic [CPU_AW-1:0]  cpu_rom_addr,
    output logic               gfx_we,
    output logic [GFX_AW-1:0]  gfx_addr,
    output logic               prom_we,
    output logic [PROM_AW-1:0] prom_addr,
    output logic [7:0]         dipsw0,
    output logic [7:0]         dipsw1,
    output logic               core_reset,
    output logic               rom_loaded,
    output logic               load_error,
    output logic [15:0]        byte_count,
    output logic [1:0]         o_dbg_state
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    // Hold counter runs 0 .. RESET_HOLD-1, so it needs clog2(RESET_HOLD) bits.
    localparam int             HCW       = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RESET_HOLD - 1);

    // Region limits are computed in 17 bits so a region ending at 0x10000 still compares correctly.
    localparam logic [16:0] CPU_END   = 17'(2 ** CPU_AW);
    localparam logic [16:0] GFX_LO    = {1'b0, GFX_BASE};
    localparam logic [16:0] GFX_END   = {1'b0, GFX_BASE} + 17'(2 ** GFX_AW);
    localparam logic [16:0] PROM_LO   = {1'b0, PROM_BASE};
    localparam logic [16:0] PROM_END  = {1'b0, PROM_BASE} + 17'(2 ** PROM_AW);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_download_q;
    logic [HCW-1:0]     r_hold_cnt;
    logic               w_core_reset;

    logic [7:0]         r_wr_data;
    logic               r_cpu_we;
    logic [CPU_AW-1:0]  r_cpu_addr;
    logic               r_gfx_we;
    logic [GFX_AW-1:0]  r_gfx_addr;
    logic               r_prom_we;
    logic [PROM_AW-1:0] r_prom_addr;
    logic [7:0]         r_dip0;
    logic [7:0]         r_dip1;
    logic               r_rom_loaded;
    logic               r_load_error;
    logic [15:0]        r_byte_count;

    logic               w_rise;
    logic               w_fall;
    logic               w_rom_start;
    logic               w_enter_load;
    logic               w_enter_run;
    logic [16:0]        w_addr17;
    logic               w_hi_zero;
    logic               w_rom_wr;
    logic               w_hit_cpu;
    logic               w_hit_gfx;
    logic               w_hit_prom;
    logic               w_hit_any;
    logic [CPU_AW-1:0]  w_cpu_addr;
    logic [GFX_AW-1:0]  w_gfx_addr;
    logic [PROM_AW-1:0] w_prom_addr;
    logic               w_dip_wr;

    assign w_rise      = ioctl_download & ~r_download_q;
    assign w_fall      = ~ioctl_download & r_download_q;
    assign w_rom_start = w_rise & (ioctl_index == 8'd0);

    assign w_enter_load = (w_state_nxt == S_LOAD) & (r_state != S_LOAD);
    assign w_enter_run  = (w_state_nxt == S_RUN) & (r_state == S_HOLD);

    // ROM decode works on the low 16 address bits; anything above them makes the byte out of map.
    assign w_addr17   = {1'b0, ioctl_addr[15:0]};
    assign w_hi_zero  = (ioctl_addr[24:16] == 9'd0);
    assign w_rom_wr   = (r_state == S_LOAD) & ioctl_wr & (ioctl_index == 8'd0);
    assign w_hit_cpu  = w_hi_zero & (w_addr17 < CPU_END);
    assign w_hit_gfx  = w_hi_zero & ~w_hit_cpu & (w_addr17 >= GFX_LO) & (w_addr17 < GFX_END);
    assign w_hit_prom = w_hi_zero & ~w_hit_cpu & ~w_hit_gfx
                        & (w_addr17 >= PROM_LO) & (w_addr17 < PROM_END);
    assign w_hit_any  = w_hit_cpu | w_hit_gfx | w_hit_prom;

    assign w_cpu_addr  = CPU_AW'(ioctl_addr[15:0]);
    assign w_gfx_addr  = GFX_AW'(ioctl_addr[15:0] - GFX_BASE);
    assign w_prom_addr = PROM_AW'(ioctl_addr[15:0] - PROM_BASE);

    assign w_dip_wr = ioctl_wr & (ioctl_index == 8'd254) & (ioctl_addr[24:3] == 22'd0);

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_BOOT;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic: only index-0 downloads move the controller; DIP downloads never do.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT: if (w_rom_start) w_state_nxt = S_LOAD;
            S_LOAD: if (w_fall) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (w_rom_start)                   w_state_nxt = S_LOAD;
                else if (r_hold_cnt == HOLD_LAST)  w_state_nxt = S_RUN;
            end
            S_RUN:  if (w_rom_start) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // Output logic: the core runs only in RUN, and is still reset there by the menu/user or any download.
    always_comb begin
        w_core_reset = 1'b1;
        if (r_state == S_RUN) w_core_reset = ext_reset | ioctl_download;
    end

    // Download edge detector. It resets to 1 so that a download already active at reset release is not seen as a start.
    always_ff @(posedge CLK) begin
        if (RESET) r_download_q <= 1'b1;
        else       r_download_q <= ioctl_download;
    end

    // Post-download hold-off counter: restarts when the load ends and counts while in HOLD.
    always_ff @(posedge CLK) begin
        if (RESET)                            r_hold_cnt <= '0;
        else if ((r_state == S_LOAD) && w_fall) r_hold_cnt <= '0;
        else if (r_state == S_HOLD)           r_hold_cnt <= r_hold_cnt + 1'b1;
    end

    // Region write strobes: one cycle after the ioctl strobe, with the region-relative address.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_data   <= '0;
            r_cpu_we    <= 1'b0;
            r_cpu_addr  <= '0;
            r_gfx_we    <= 1'b0;
            r_gfx_addr  <= '0;
            r_prom_we   <= 1'b0;
            r_prom_addr <= '0;
        end else begin
            r_cpu_we  <= w_rom_wr & w_hit_cpu;
            r_gfx_we  <= w_rom_wr & w_hit_gfx;
            r_prom_we <= w_rom_wr & w_hit_prom;
            if (w_rom_wr & w_hit_any)  r_wr_data   <= ioctl_dout;
            if (w_rom_wr & w_hit_cpu)  r_cpu_addr  <= w_cpu_addr;
            if (w_rom_wr & w_hit_gfx)  r_gfx_addr  <= w_gfx_addr;
            if (w_rom_wr & w_hit_prom) r_prom_addr <= w_prom_addr;
        end
    end

    // Load status: cleared on every LOAD entry. The error is sticky and the byte count saturates.
    always_ff @(posedge CLK) begin
        if (RESET || w_enter_load) begin
            r_rom_loaded <= 1'b0;
            r_load_error <= 1'b0;
            r_byte_count <= '0;
        end else begin
            if (w_enter_run) r_rom_loaded <= 1'b1;
            if (w_rom_wr & ~w_hit_any) r_load_error <= 1'b1;
            if (w_rom_wr & w_hit_any & (r_byte_count != 16'hFFFF))
                r_byte_count <= r_byte_count + 16'd1;
        end
    end

    // DIP-switch capture from index-254 downloads, accepted in any state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dip0 <= '0;
            r_dip1 <= '0;
        end else if (w_dip_wr) begin
            if (ioctl_addr[2:0] == 3'd0) r_dip0 <= ioctl_dout;
            if (ioctl_addr[2:0] == 3'd1) r_dip1 <= ioctl_dout;
        end
    end

    assign wr_data      = r_wr_data;
    assign cpu_rom_we   = r_cpu_we;
    assign cpu_rom_addr = r_cpu_addr;
    assign gfx_we       = r_gfx_we;
    assign gfx_addr     = r_gfx_addr;
    assign prom_we      = r_prom_we;
    assign prom_addr    = r_prom_addr;
    assign dipsw0       = r_dip0;
    assign dipsw1       = r_dip1;
    assign core_reset   = w_core_reset;
    assign rom_loaded   = r_rom_loaded;
    assign load_error   = r_load_error;
    assign byte_count   = r_byte_count;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/rom_download_ctrl.md
Name: rom_download_ctrl

Overview:
- Sequences the HPS ioctl download stream into the core's ROM regions: CPU program ROM, graphics ROM and colour PROM.
- Captures the MRA DIP-switch bytes.
- Owns the core reset: holds the core in reset through power-up, through every download and for a programmable hold-off afterwards, then releases it.
- Sits between hps_io and the CRAZYBALLOON core. It replaces the ad-hoc reset OR and DIP capture in the top level.

Parameters:
- RESET_HOLD, 16, number of CLK cycles core_reset stays high after a ROM download ends (minimum 1).
- CPU_AW, 14, CPU ROM address width; the region is 0x0000 to 2^CPU_AW-1.
- GFX_BASE, 16'h4000, first download address of the graphics ROM.
- GFX_AW, 11, graphics ROM address width.
- PROM_BASE, 16'h4800, first download address of the colour PROM.
- PROM_AW, 5, colour PROM address width.

Ports:
- CLK  in  1  system clock (clk_sys domain).
- RESET  in  1  synchronous reset, active-high.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_index  in  8  0 = ROM set, 254 = DIP switches.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ext_reset  in  1  menu reset OR user button.
- wr_data  out  8  registered write data, shared by all regions.
- cpu_rom_we  out  1  CPU ROM write strobe.
- cpu_rom_addr  out  CPU_AW  CPU ROM write address.
- gfx_we  out  1  graphics ROM write strobe.
- gfx_addr  out  GFX_AW  graphics ROM write address.
- prom_we  out  1  colour PROM write strobe.
- prom_addr  out  PROM_AW  colour PROM write address.
- dipsw0  out  8  DIP byte 0.
- dipsw1  out  8  DIP byte 1.
- core_reset  out  1  reset to the core.
- rom_loaded  out  1  a complete ROM load has finished.
- load_error  out  1  an out-of-map byte was seen in the current or last load.
- byte_count  out  16  accepted ROM bytes in the current or last load.

Behaviour:
Reset values:
- State is BOOT; core_reset=1.
- All *_we=0, all addresses=0, wr_data=0.
- dipsw0=dipsw1=0.
- rom_loaded=0, load_error=0, byte_count=0.
- download_q=1, so a download already in progress when RESET deasserts is ignored until it ends and a new one starts.

Download edges:
- download_q registers ioctl_download every cycle.
- Rising edge means ioctl_download=1 and download_q=0.
- Falling edge means ioctl_download=0 and download_q=1.

FSM states: BOOT, LOAD, HOLD, RUN.
- BOOT: core_reset=1. A rising edge with ioctl_index=0 goes to LOAD. Index-254 downloads stay in BOOT.
- LOAD: core_reset=1. A falling edge goes to HOLD and clears the hold counter.
- HOLD: core_reset=1. The counter increments each cycle. At count RESET_HOLD-1 go to RUN and set rom_loaded=1. A rising edge with index 0 returns to LOAD. ext_reset is ignored in HOLD.
- RUN: core_reset = ext_reset | ioctl_download, combinational from registered state. A rising edge with index 0 goes to LOAD.

Entry into LOAD, on the same edge:
- rom_loaded, load_error and byte_count are cleared.

ROM writes (state LOAD, ioctl_wr=1, ioctl_index=0):
- Decode uses ioctl_addr[15:0]. Address bits [24:16] must be 0, otherwise the byte is out of map.
- Latency is 1 cycle: the next cycle asserts exactly one *_we for one cycle, with the matching address and wr_data=ioctl_dout.
- addr < 2^CPU_AW: cpu_rom_addr = addr.
- GFX_BASE ≤ addr < GFX_BASE+2^GFX_AW: gfx_addr = addr-GFX_BASE.
- PROM_BASE ≤ addr < PROM_BASE+2^PROM_AW: prom_addr = addr-PROM_BASE.
- Otherwise: no strobe, load_error=1 (sticky until the next LOAD entry), byte_count is not incremented.
- An accepted byte increments byte_count, saturating at 16'hFFFF.
- ioctl_wr outside LOAD, or with a non-zero index, produces no ROM strobe.

DIP capture (any state, ioctl_wr=1, ioctl_index=254, ioctl_addr[24:3]=0):
- addr[2:0]=0 writes dipsw0; addr[2:0]=1 writes dipsw1; other values are ignored.
- The write takes effect on the next cycle.

Simultaneous events:
- A falling edge and ioctl_wr in the same cycle: the byte is still accepted, because it is decoded from the LOAD state.
- RESET takes priority over everything and aborts LOAD or HOLD immediately.

Test Plan:
- Reset, then download index 0 writing 0x00=AA, 0x4001=BB, 0x4805=CC, 0x5000=DD, then drop download → one-cycle strobes appear in order:
  - cpu_rom_we with addr 0x0000, data AA;
  - gfx_we with addr 0x001, data BB;
  - prom_we with addr 0x05, data CC;
  - no strobe for 0x5000; load_error=1; byte_count=3.
- Same load, then count cycles after the falling edge → core_reset stays 1 for exactly 16 cycles; on the RUN transition rom_loaded=1 and core_reset=0.
- In RUN, pulse ext_reset for 3 cycles → core_reset=1 for exactly those 3 cycles. Then run an index-254 download writing addr0=5A, addr1=C3, addr2=FF → dipsw0=5A, dipsw1=C3; core_reset=1 only while download is high; rom_loaded stays 1.
- Hold RESET high while ioctl_download=1 with index 0, release RESET mid-download and keep strobing → no *_we strobes and state stays BOOT. After the download drops and a new one rises, writes are accepted.
- Eight cycles into HOLD, start a new index-0 download → state returns to LOAD; byte_count, load_error and rom_loaded are cleared; core_reset never drops.
- 70000 accepted CPU-region writes (addresses wrapping within the region) → byte_count saturates at FFFF and does not wrap.
